// File: rtl/alu_rs_if.sv
// Issue, common-data-bus and dispatch signals of the ALU reservation station.
// The RS side uses the slave modport and the decoder/CDB/ALU side uses master.
interface alu_rs_if;
  // Handshake: alu_in_en is a one-cycle issue strobe with no ready return.
  // The issuer must hold off whenever rs_full=1. exec_en is a one-cycle valid
  // pulse toward the ALU, which always accepts it.
  logic        alu_in_en;
  logic [4:0]  alu_op_type;
  logic [4:0]  vdest_id;
  logic        op1_dependent;
  logic        op2_dependent;
  logic [31:0] op1;
  logic [31:0] op2;

  logic        cdb0_en;
  logic [4:0]  cdb0_id;
  logic [31:0] cdb0_val;
  logic        cdb1_en;
  logic [4:0]  cdb1_id;
  logic [31:0] cdb1_val;

  logic        rs_full;
  logic        exec_en;
  logic [4:0]  exec_op_type;
  logic [4:0]  exec_dest;
  logic [31:0] exec_op1;
  logic [31:0] exec_op2;

  modport slave (
    input  alu_in_en, alu_op_type, vdest_id, op1_dependent, op2_dependent, op1, op2,
    input  cdb0_en, cdb0_id, cdb0_val, cdb1_en, cdb1_id, cdb1_val,
    output rs_full, exec_en, exec_op_type, exec_dest, exec_op1, exec_op2
  );

  modport master (
    output alu_in_en, alu_op_type, vdest_id, op1_dependent, op2_dependent, op1, op2,
    output cdb0_en, cdb0_id, cdb0_val, cdb1_en, cdb1_id, cdb1_val,
    input  rs_full, exec_en, exec_op_type, exec_dest, exec_op1, exec_op2
  );
endinterface

// File: rtl/alu_rs.sv
// Eight-entry ALU reservation station. It wakes operands from two CDB ports,
// allocates the lowest free slot and dispatches the lowest ready slot each cycle.
module alu_rs (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    rob_rst,
  alu_rs_if.slave bus
);
  localparam int N = 8;

  typedef struct packed {
    logic        valid;
    logic [4:0]  op_type;
    logic [4:0]  dest;
    logic        q1_busy;
    logic [31:0] v1;
    logic        q2_busy;
    logic [31:0] v2;
  } ent_t;

  ent_t        ent_q [N];
  ent_t        ent_d [N];
  logic        exec_en_q, exec_en_d;
  logic [4:0]  exec_op_type_q, exec_op_type_d;
  logic [4:0]  exec_dest_q, exec_dest_d;
  logic [31:0] exec_op1_q, exec_op1_d;
  logic [31:0] exec_op2_q, exec_op2_d;

  logic [N-1:0] free_vec;
  logic [N-1:0] ready_vec;
  logic [3:0]   free_cnt;
  logic         alloc_found;
  logic [2:0]   alloc_idx;
  logic         disp_found;
  logic [2:0]   disp_idx;

  // Returns {busy, value}. A pending operand holds its tag in value[4:0],
  // and port 0 takes precedence when both ports broadcast that tag.
  function automatic logic [32:0] resolve_src(
    input logic        busy,
    input logic [31:0] val,
    input logic        c0_en,
    input logic [4:0]  c0_id,
    input logic [31:0] c0_val,
    input logic        c1_en,
    input logic [4:0]  c1_id,
    input logic [31:0] c1_val
  );
    logic [32:0] res;
    res = {busy, val};
    if (busy) begin
      if (c0_en && (c0_id == val[4:0])) begin
        res = {1'b0, c0_val};
      end else if (c1_en && (c1_id == val[4:0])) begin
        res = {1'b0, c1_val};
      end
    end
    return res;
  endfunction

  // Both scans read only the start-of-cycle state, so a slot freed by
  // dispatch this cycle is not handed out again until the next cycle.
  always_comb begin
    free_vec    = '0;
    ready_vec   = '0;
    free_cnt    = '0;
    alloc_found = 1'b0;
    alloc_idx   = '0;
    disp_found  = 1'b0;
    disp_idx    = '0;
    for (int i = 0; i < N; i++) begin
      free_vec[i]  = !ent_q[i].valid;
      ready_vec[i] = ent_q[i].valid && !ent_q[i].q1_busy && !ent_q[i].q2_busy;
      free_cnt     = free_cnt + 4'(free_vec[i]);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (free_vec[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = 3'(i);
      end
      if (ready_vec[i]) begin
        disp_found = 1'b1;
        disp_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ent_d[i] = ent_q[i];
    end
    exec_en_d      = 1'b0;
    exec_op_type_d = exec_op_type_q;
    exec_dest_d    = exec_dest_q;
    exec_op1_d     = exec_op1_q;
    exec_op2_d     = exec_op2_q;

    if (rob_rst) begin
      for (int i = 0; i < N; i++) begin
        ent_d[i].valid = 1'b0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (ent_q[i].valid) begin
          {ent_d[i].q1_busy, ent_d[i].v1} = resolve_src(ent_q[i].q1_busy, ent_q[i].v1,
            bus.cdb0_en, bus.cdb0_id, bus.cdb0_val, bus.cdb1_en, bus.cdb1_id, bus.cdb1_val);
          {ent_d[i].q2_busy, ent_d[i].v2} = resolve_src(ent_q[i].q2_busy, ent_q[i].v2,
            bus.cdb0_en, bus.cdb0_id, bus.cdb0_val, bus.cdb1_en, bus.cdb1_id, bus.cdb1_val);
        end
      end

      if (disp_found) begin
        exec_en_d             = 1'b1;
        exec_op_type_d        = ent_q[disp_idx].op_type;
        exec_dest_d           = ent_q[disp_idx].dest;
        exec_op1_d            = ent_q[disp_idx].v1;
        exec_op2_d            = ent_q[disp_idx].v2;
        ent_d[disp_idx].valid = 1'b0;
      end

      // An incoming pending operand can be satisfied by this cycle's broadcast.
      if (bus.alu_in_en && alloc_found) begin
        ent_d[alloc_idx].valid   = 1'b1;
        ent_d[alloc_idx].op_type = bus.alu_op_type;
        ent_d[alloc_idx].dest    = bus.vdest_id;
        {ent_d[alloc_idx].q1_busy, ent_d[alloc_idx].v1} = resolve_src(bus.op1_dependent, bus.op1,
          bus.cdb0_en, bus.cdb0_id, bus.cdb0_val, bus.cdb1_en, bus.cdb1_id, bus.cdb1_val);
        {ent_d[alloc_idx].q2_busy, ent_d[alloc_idx].v2} = resolve_src(bus.op2_dependent, bus.op2,
          bus.cdb0_en, bus.cdb0_id, bus.cdb0_val, bus.cdb1_en, bus.cdb1_id, bus.cdb1_val);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= '0;
      end
      exec_en_q      <= 1'b0;
      exec_op_type_q <= '0;
      exec_dest_q    <= '0;
      exec_op1_q     <= '0;
      exec_op2_q     <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        ent_q[i] <= ent_d[i];
      end
      exec_en_q      <= exec_en_d;
      exec_op_type_q <= exec_op_type_d;
      exec_dest_q    <= exec_dest_d;
      exec_op1_q     <= exec_op1_d;
      exec_op2_q     <= exec_op2_d;
    end
  end

  // Two free slots are needed to absorb the decoder's one-cycle issue latency.
  assign bus.rs_full      = (free_cnt <= 4'd1);
  assign bus.exec_en      = exec_en_q;
  assign bus.exec_op_type = exec_op_type_q;
  assign bus.exec_dest    = exec_dest_q;
  assign bus.exec_op1     = exec_op1_q;
  assign bus.exec_op2     = exec_op2_q;
endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: reset, issue, wakeup, bypass, fill, flush
// and mid-operation reset, each with hand-computed expectations.
module tb_alu_rs;
  logic clk = 1'b0;
  logic rst_n;
  logic rob_rst;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  alu_rs_if bus();

  alu_rs dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rob_rst(rob_rst),
    .bus    (bus.slave)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic clear_issue;
    bus.alu_in_en     = 1'b0;
    bus.alu_op_type   = '0;
    bus.vdest_id      = '0;
    bus.op1_dependent = 1'b0;
    bus.op2_dependent = 1'b0;
    bus.op1           = '0;
    bus.op2           = '0;
  endtask

  task automatic clear_cdb;
    bus.cdb0_en  = 1'b0;
    bus.cdb0_id  = '0;
    bus.cdb0_val = '0;
    bus.cdb1_en  = 1'b0;
    bus.cdb1_id  = '0;
    bus.cdb1_val = '0;
  endtask

  task automatic drive_issue(input logic [4:0] op, input logic [4:0] dest,
                             input logic d1, input logic [31:0] o1,
                             input logic d2, input logic [31:0] o2);
    bus.alu_in_en     = 1'b1;
    bus.alu_op_type   = op;
    bus.vdest_id      = dest;
    bus.op1_dependent = d1;
    bus.op1           = o1;
    bus.op2_dependent = d2;
    bus.op2           = o2;
  endtask

  task automatic drive_cdb0(input logic [4:0] id, input logic [31:0] val);
    bus.cdb0_en  = 1'b1;
    bus.cdb0_id  = id;
    bus.cdb0_val = val;
  endtask

  task automatic drive_cdb1(input logic [4:0] id, input logic [31:0] val);
    bus.cdb1_en  = 1'b1;
    bus.cdb1_id  = id;
    bus.cdb1_val = val;
  endtask

  // Scenarios
  task automatic test_reset;
    rst_n = 1'b0;
    rob_rst = 1'b0;
    clear_issue();
    clear_cdb();
    tick();
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL reset_exec_en got=%0b exp=0", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_op_type !== 5'd0) $display("FAIL reset_op_type got=%0d exp=0", bus.exec_op_type); else pass_cnt++;
    total_cnt++; if (bus.exec_dest !== 5'd0) $display("FAIL reset_dest got=%0d exp=0", bus.exec_dest); else pass_cnt++;
    total_cnt++; if (bus.exec_op1 !== 32'd0) $display("FAIL reset_op1 got=%0h exp=0", bus.exec_op1); else pass_cnt++;
    total_cnt++; if (bus.exec_op2 !== 32'd0) $display("FAIL reset_op2 got=%0h exp=0", bus.exec_op2); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++; if (bus.rs_full !== 1'b0) $display("FAIL reset_rs_full got=%0b exp=0", bus.rs_full); else pass_cnt++;
  endtask

  task automatic test_ready_issue;
    drive_issue(5'd0, 5'd3, 1'b0, 32'd5, 1'b0, 32'd7);
    tick();
    clear_issue();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL ready_early got=%0b exp=0", bus.exec_en); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b1) $display("FAIL ready_en got=%0b exp=1", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_op1 !== 32'd5) $display("FAIL ready_op1 got=%0h exp=5", bus.exec_op1); else pass_cnt++;
    total_cnt++; if (bus.exec_op2 !== 32'd7) $display("FAIL ready_op2 got=%0h exp=7", bus.exec_op2); else pass_cnt++;
    total_cnt++; if (bus.exec_dest !== 5'd3) $display("FAIL ready_dest got=%0d exp=3", bus.exec_dest); else pass_cnt++;
    total_cnt++; if (bus.exec_op_type !== 5'd0) $display("FAIL ready_op_type got=%0d exp=0", bus.exec_op_type); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL ready_pulse got=%0b exp=0", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_op1 !== 32'd5) $display("FAIL ready_hold got=%0h exp=5", bus.exec_op1); else pass_cnt++;
  endtask

  task automatic test_wakeup;
    drive_issue(5'd2, 5'd7, 1'b1, 32'd9, 1'b0, 32'd3);
    tick();
    clear_issue();
    // Wrong tag on port 0 and the right tag with port 1 disabled must not wake it.
    drive_cdb0(5'd8, 32'hDEAD);
    bus.cdb1_id  = 5'd9;
    bus.cdb1_val = 32'hBEEF;
    tick();
    clear_cdb();
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL wake_no_match got=%0b exp=0", bus.exec_en); else pass_cnt++;
    drive_cdb1(5'd9, 32'h1234);
    tick();
    clear_cdb();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL wake_same_cycle got=%0b exp=0", bus.exec_en); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b1) $display("FAIL wake_en got=%0b exp=1", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_op1 !== 32'h1234) $display("FAIL wake_op1 got=%0h exp=1234", bus.exec_op1); else pass_cnt++;
    total_cnt++; if (bus.exec_op2 !== 32'd3) $display("FAIL wake_op2 got=%0h exp=3", bus.exec_op2); else pass_cnt++;
    total_cnt++; if (bus.exec_dest !== 5'd7) $display("FAIL wake_dest got=%0d exp=7", bus.exec_dest); else pass_cnt++;
    total_cnt++; if (bus.exec_op_type !== 5'd2) $display("FAIL wake_op_type got=%0d exp=2", bus.exec_op_type); else pass_cnt++;
    tick();
  endtask

  task automatic test_bypass;
    drive_issue(5'd1, 5'd12, 1'b0, 32'd1, 1'b1, 32'd4);
    drive_cdb0(5'd4, 32'hAA);
    drive_cdb1(5'd4, 32'hBB);
    tick();
    clear_issue();
    clear_cdb();
    tick();
    total_cnt++; if (bus.exec_en !== 1'b1) $display("FAIL bypass_en got=%0b exp=1", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_op2 !== 32'hAA) $display("FAIL bypass_op2 got=%0h exp=aa", bus.exec_op2); else pass_cnt++;
    total_cnt++; if (bus.exec_dest !== 5'd12) $display("FAIL bypass_dest got=%0d exp=12", bus.exec_dest); else pass_cnt++;
    // Priority on an already stored operand
    drive_issue(5'd3, 5'd13, 1'b0, 32'd2, 1'b1, 32'd6);
    tick();
    clear_issue();
    drive_cdb0(5'd6, 32'h11);
    drive_cdb1(5'd6, 32'h22);
    tick();
    clear_cdb();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL prio_early got=%0b exp=0", bus.exec_en); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b1) $display("FAIL prio_en got=%0b exp=1", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_op2 !== 32'h11) $display("FAIL prio_op2 got=%0h exp=11", bus.exec_op2); else pass_cnt++;
    tick();
  endtask

  task automatic test_fill;
    logic exp_full;
    for (int i = 0; i < 8; i++) begin
      drive_issue(5'd1, 5'(i), 1'b1, 32'(10 + i), 1'b0, 32'(i));
      tick();
      if (i == 5) begin
        total_cnt++; if (bus.rs_full !== 1'b0) $display("FAIL fill_six got=%0b exp=0", bus.rs_full); else pass_cnt++;
      end
      if (i == 6) begin
        total_cnt++; if (bus.rs_full !== 1'b1) $display("FAIL fill_seven got=%0b exp=1", bus.rs_full); else pass_cnt++;
      end
    end
    // Ninth issue has no free slot and must vanish.
    drive_issue(5'd1, 5'd8, 1'b1, 32'd18, 1'b0, 32'd8);
    tick();
    clear_issue();
    total_cnt++; if (bus.rs_full !== 1'b1) $display("FAIL fill_full got=%0b exp=1", bus.rs_full); else pass_cnt++;
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL fill_no_disp got=%0b exp=0", bus.exec_en); else pass_cnt++;
    // Wake pairs with the higher index on port 0; dispatch must still go low index first.
    for (int p = 0; p < 4; p++) begin
      drive_cdb0(5'(10 + 2 * p + 1), 32'(32'h200 + 2 * p + 1));
      drive_cdb1(5'(10 + 2 * p), 32'(32'h200 + 2 * p));
      tick();
      clear_cdb();
      total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL drain_idle p=%0d got=%0b exp=0", p, bus.exec_en); else pass_cnt++;
      tick();
      exp_full = (2 * p + 1) <= 1;
      total_cnt++; if (bus.exec_en !== 1'b1) $display("FAIL drain_en_a p=%0d got=%0b exp=1", p, bus.exec_en); else pass_cnt++;
      total_cnt++; if (bus.exec_dest !== 5'(2 * p)) $display("FAIL drain_dest_a p=%0d got=%0d exp=%0d", p, bus.exec_dest, 2 * p); else pass_cnt++;
      total_cnt++; if (bus.exec_op1 !== 32'(32'h200 + 2 * p)) $display("FAIL drain_op1_a p=%0d got=%0h exp=%0h", p, bus.exec_op1, 32'h200 + 2 * p); else pass_cnt++;
      total_cnt++; if (bus.rs_full !== exp_full) $display("FAIL drain_full_a p=%0d got=%0b exp=%0b", p, bus.rs_full, exp_full); else pass_cnt++;
      tick();
      total_cnt++; if (bus.exec_en !== 1'b1) $display("FAIL drain_en_b p=%0d got=%0b exp=1", p, bus.exec_en); else pass_cnt++;
      total_cnt++; if (bus.exec_dest !== 5'(2 * p + 1)) $display("FAIL drain_dest_b p=%0d got=%0d exp=%0d", p, bus.exec_dest, 2 * p + 1); else pass_cnt++;
      total_cnt++; if (bus.exec_op1 !== 32'(32'h200 + 2 * p + 1)) $display("FAIL drain_op1_b p=%0d got=%0h exp=%0h", p, bus.exec_op1, 32'h200 + 2 * p + 1); else pass_cnt++;
      total_cnt++; if (bus.rs_full !== 1'b0) $display("FAIL drain_full_b p=%0d got=%0b exp=0", p, bus.rs_full); else pass_cnt++;
    end
    drive_cdb0(5'd18, 32'h999);
    tick();
    clear_cdb();
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL fill_dropped got=%0b exp=0", bus.exec_en); else pass_cnt++;
  endtask

  task automatic test_flush;
    drive_issue(5'd1, 5'd1, 1'b1, 32'd20, 1'b0, 32'd0);
    tick();
    drive_issue(5'd1, 5'd2, 1'b1, 32'd21, 1'b0, 32'd0);
    tick();
    drive_issue(5'd1, 5'd3, 1'b0, 32'h55, 1'b0, 32'd0);
    tick();
    // The ready entry would dispatch at this edge without the flush.
    drive_issue(5'd1, 5'd4, 1'b0, 32'h66, 1'b0, 32'd0);
    rob_rst = 1'b1;
    tick();
    rob_rst = 1'b0;
    clear_issue();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL flush_en got=%0b exp=0", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.rs_full !== 1'b0) $display("FAIL flush_full got=%0b exp=0", bus.rs_full); else pass_cnt++;
    drive_cdb0(5'd20, 32'h1);
    drive_cdb1(5'd21, 32'h2);
    tick();
    clear_cdb();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL flush_after_a got=%0b exp=0", bus.exec_en); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL flush_after_b got=%0b exp=0", bus.exec_en); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL flush_after_c got=%0b exp=0", bus.exec_en); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    drive_issue(5'd2, 5'd5, 1'b0, 32'h77, 1'b0, 32'd1);
    tick();
    drive_issue(5'd2, 5'd6, 1'b0, 32'h88, 1'b0, 32'd1);
    tick();
    clear_issue();
    total_cnt++; if (bus.exec_en !== 1'b1) $display("FAIL mid_pre_en got=%0b exp=1", bus.exec_en); else pass_cnt++;
    rst_n = 1'b0;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL mid_en got=%0b exp=0", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_op1 !== 32'd0) $display("FAIL mid_op1 got=%0h exp=0", bus.exec_op1); else pass_cnt++;
    total_cnt++; if (bus.exec_op2 !== 32'd0) $display("FAIL mid_op2 got=%0h exp=0", bus.exec_op2); else pass_cnt++;
    total_cnt++; if (bus.exec_dest !== 5'd0) $display("FAIL mid_dest got=%0d exp=0", bus.exec_dest); else pass_cnt++;
    total_cnt++; if (bus.exec_op_type !== 5'd0) $display("FAIL mid_op_type got=%0d exp=0", bus.exec_op_type); else pass_cnt++;
    rst_n = 1'b1;
    tick();
    total_cnt++; if (bus.rs_full !== 1'b0) $display("FAIL mid_full got=%0b exp=0", bus.rs_full); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL mid_no_disp got=%0b exp=0", bus.exec_en); else pass_cnt++;
    drive_issue(5'd4, 5'd9, 1'b0, 32'h99, 1'b0, 32'd2);
    tick();
    clear_issue();
    tick();
    total_cnt++; if (bus.exec_en !== 1'b1) $display("FAIL mid_new_en got=%0b exp=1", bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_dest !== 5'd9) $display("FAIL mid_new_dest got=%0d exp=9", bus.exec_dest); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back;
    drive_issue(5'd5, 5'd10, 1'b0, 32'hA0, 1'b0, 32'd0);
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL b2b_first got=%0b exp=0", bus.exec_en); else pass_cnt++;
    drive_issue(5'd5, 5'd11, 1'b0, 32'hA1, 1'b0, 32'd0);
    tick();
    total_cnt++; if (bus.exec_dest !== 5'd10 || bus.exec_en !== 1'b1) $display("FAIL b2b_a got=%0d/%0b exp=10/1", bus.exec_dest, bus.exec_en); else pass_cnt++;
    drive_issue(5'd5, 5'd12, 1'b0, 32'hA2, 1'b0, 32'd0);
    tick();
    clear_issue();
    total_cnt++; if (bus.exec_dest !== 5'd11 || bus.exec_en !== 1'b1) $display("FAIL b2b_b got=%0d/%0b exp=11/1", bus.exec_dest, bus.exec_en); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_dest !== 5'd12 || bus.exec_en !== 1'b1) $display("FAIL b2b_c got=%0d/%0b exp=12/1", bus.exec_dest, bus.exec_en); else pass_cnt++;
    total_cnt++; if (bus.exec_op1 !== 32'hA2) $display("FAIL b2b_op1 got=%0h exp=a2", bus.exec_op1); else pass_cnt++;
    tick();
    total_cnt++; if (bus.exec_en !== 1'b0) $display("FAIL b2b_end got=%0b exp=0", bus.exec_en); else pass_cnt++;
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_ready_issue();
    test_wakeup();
    test_bypass();
    test_fill();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/alu_rs.md
ALU_RS -- requirements
Module: alu_rs

Interface
REQ-001 clk  in  1  sole clock; all state changes on its rising edge.
REQ-002 rst_n  in  1  synchronous active-low reset, sampled on rising clk edge.
REQ-003 rob_rst  in  1  pipeline flush from ROB; active high.
REQ-004 alu_in_en  in  1  decoder issues one ALU instruction this cycle.
REQ-005 alu_op_type  in  5  ALU operation code; stored without interpretation.
REQ-006 vdest_id  in  5  ROB tag of the instruction's result.
REQ-007 op1_dependent / op2_dependent  in  1 each  operand pending; when set, op1/op2[4:0] holds the producing ROB tag.
REQ-008 op1 / op2  in  32 each  operand value, or tag when dependent.
REQ-009 cdb0_en, cdb0_id[4:0], cdb0_val[31:0]  in  result broadcast port 0 (ALU).
REQ-010 cdb1_en, cdb1_id[4:0], cdb1_val[31:0]  in  result broadcast port 1 (LSB/muldiv).
REQ-011 rs_full  out  1  fewer than 2 free entries; instruction queue stops issuing.
REQ-012 exec_en  out  1  registered; dispatch valid to ALU this cycle.
REQ-013 exec_op_type  out  5; exec_dest  out  5; exec_op1, exec_op2  out  32 each  registered dispatch payload.

Function
REQ-014 8 entries, each holding: valid, op_type, dest, q1_busy, v1/q1, q2_busy, v2/q2.
REQ-015 Allocation: when alu_in_en=1 and rob_rst=0, write the lowest-index entry that was free at the start of the cycle.
REQ-016 A slot freed by dispatch in cycle N SHALL NOT be reallocated in cycle N; it is reusable from cycle N+1.
REQ-017 alu_in_en with no free entry: instruction dropped, no state change (protocol violation; rs_full prevents it).
REQ-018 rs_full is combinational from the valid bits: 1 when free count <= 1, covering the one-cycle decoder latency.
REQ-019 Wakeup: for every valid entry with qX_busy=1, a cdbK_en=1 with cdbK_id==qX SHALL capture cdbK_val and clear qX_busy at that edge.
REQ-020 Both CDB ports SHALL be checked every cycle; if both match the same operand, port 0 SHALL win.
REQ-021 Same-cycle bypass: an incoming dependent operand whose tag matches an active CDB port in the allocation cycle SHALL be stored ready with the CDB value.
REQ-022 Ready means valid=1, q1_busy=0 and q2_busy=0 at the start of the cycle; wakeups in cycle N make an entry eligible in cycle N+1.
REQ-023 Dispatch: each cycle, the lowest-index ready entry SHALL be registered onto exec_* with exec_en=1 and its valid cleared at the same edge.
REQ-024 Dispatch rate: at most one per cycle; no ready entry -> exec_en=0 next cycle, payload holds its previous value.
REQ-025 Minimum latency: allocation at edge N with both operands ready -> exec_en=1 after edge N+1.
REQ-026 exec_en is a one-cycle pulse per dispatched instruction; the ALU has no backpressure.
REQ-027 Flush: rob_rst=1 at an edge SHALL clear all valid bits, force exec_en=0 and ignore alu_in_en and CDB in that cycle.
REQ-028 Tags are 5 bits; no wrap handling is required beyond exact equality compare.

Reset
REQ-029 rst_n=0 at an edge clears all entry valid bits and sets exec_en=0, exec_op_type=0, exec_dest=0, exec_op1=0, exec_op2=0.
REQ-030 rst_n has priority over rob_rst, alu_in_en and CDB inputs; rs_full=0 in the cycle after reset.

Verification
REQ-031 Ready issue: alu_in_en with op_type=0, op1=5, op2=7, dest=3, both ready -> exactly two edges later, exec_en=1, exec_op1=5, exec_op2=7, exec_dest=3.
REQ-032 Wakeup: dependent op1 tag=9, then cdb1_en with id=9, val=0x1234 -> dispatch occurs the cycle after the broadcast, with exec_op1=0x1234.
REQ-033 Bypass and priority: allocate op2 dependent on tag 4 in the same cycle as cdb0(id 4, val 0xAA) and cdb1(id 4, val 0xBB) -> stored and dispatched op2=0xAA.
REQ-034 Fill: 7 non-ready entries -> rs_full=1; 8th accepted; 9th dropped; each broadcast then frees one slot, entries dispatch in index order, rs_full drops once 2 entries are free.
REQ-035 Flush: 3 valid entries plus alu_in_en with rob_rst=1 -> next cycle exec_en=0, rs_full=0, and later matching CDB broadcasts produce no dispatch.
REQ-036 Reset mid-operation: rst_n=0 while entries are ready and exec_en=1 -> all outputs 0 at the next edge; no dispatch until new allocation.
